// File: rtl/wb_controller.sv
// wb_controller -- write-back stage controller for a simple in-order pipeline.
//
// It accepts one instruction at a time from the memory-access stage. Each
// instruction can do one of three things:
//   - write pc+4 to r15 (call),
//   - wait for load data and write it to rd (load),
//   - write the ALU result to rd (ALU write-back).
// An instruction that asks for none of these retires with no write.
// A load that sees no data return for 15 cycles parks the controller in a
// sticky error state. Only reset leaves that state.
//
// Ports
//   clk, rst_n              clock (rising edge) and async active-low reset
//   in_valid / in_ready     instruction handshake from the memory stage
//   aluResult, pc, rd       instruction payload
//   isLd, isCall, isWb      instruction class flags (call > load > wb priority)
//   mem_rvalid, mem_rdata   load data return
//   rf_we/rf_waddr/rf_wdata registered register-file write port
//   busy                    controller is not idle
//   ld_err                  sticky load-timeout flag
//   wb_count                saturating count of retired register writes
module wb_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] aluResult,
  input  logic [31:0] pc,
  input  logic [3:0]  rd,
  input  logic        isLd,
  input  logic        isCall,
  input  logic        isWb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        busy,
  output logic        ld_err,
  output logic [15:0] wb_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_LD = 2'd1;
  localparam logic [1:0] WRITE   = 2'd2;
  localparam logic [1:0] ERR     = 2'd3;

  // Last wait_cnt value that still allows another cycle without data.
  // 15 cycles without data in total end in ERR.
  localparam logic [3:0] WAIT_LAST = 4'd14;
  localparam logic [3:0] CALL_REG  = 4'd15;

  logic [1:0]  state, state_nx;
  logic        live;      // low while in reset and up to the first edge after release
  logic [3:0]  ld_rd;     // destination register of the load in flight
  logic [3:0]  wait_cnt;
  logic        accept;
  logic        wr_nx;
  logic [3:0]  waddr_nx;
  logic [31:0] wdata_nx;

  // Gating in_ready with live keeps in_ready low during reset.
  // It also holds in_ready low until the first edge after rst_n rises.
  assign in_ready = live & ((state == IDLE) | (state == WRITE));
  assign accept   = in_valid & in_ready;
  assign busy     = (state != IDLE);

  // Next-state and write-port decode. The write-port registers load their
  // new address and data on the same edge that enters WRITE. That way
  // rf_we, rf_waddr and rf_wdata all line up with the WRITE state.
  always_comb begin
    state_nx = state;
    wr_nx    = 1'b0;
    waddr_nx = rf_waddr;
    wdata_nx = rf_wdata;
    case (state)
      IDLE, WRITE: begin
        state_nx = IDLE;
        if (accept) begin
          if (isCall) begin
            // A call always links to r15. rd and isLd are ignored.
            state_nx = WRITE;
            wr_nx    = 1'b1;
            waddr_nx = CALL_REG;
            wdata_nx = pc + 32'd4;
          end else if (isLd) begin
            state_nx = WAIT_LD;
          end else if (isWb) begin
            state_nx = WRITE;
            wr_nx    = 1'b1;
            waddr_nx = rd;
            wdata_nx = aluResult;
          end
        end
      end
      WAIT_LD: begin
        // Returned data wins over a timeout in the same cycle.
        if (mem_rvalid) begin
          state_nx = WRITE;
          wr_nx    = 1'b1;
          waddr_nx = ld_rd;
          wdata_nx = mem_rdata;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx = ERR;
        end
      end
      ERR:     state_nx = ERR;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      live  <= 1'b0;
    end else begin
      state <= state_nx;
      live  <= 1'b1;
    end
  end

  // A load's destination is captured when the load is accepted. It is used
  // later, when the data returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ld_rd <= '0;
    else if (accept) ld_rd <= rd;
  end

  // wait_cnt counts cycles without data in WAIT_LD. It is cleared on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state_nx == WAIT_LD) begin
      if (state != WAIT_LD) wait_cnt <= '0;
      else                  wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Register-file write port. Address and data hold their values between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= wr_nx;
      if (wr_nx) begin
        rf_waddr <= waddr_nx;
        rf_wdata <= wdata_nx;
      end
    end
  end

  // wb_count steps on the same edge that raises rf_we. The count is then
  // already current during the write cycle. It saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_count <= '0;
    end else if (wr_nx && (wb_count != 16'hFFFF)) begin
      wb_count <= wb_count + 16'd1;
    end
  end

  // ld_err is sticky. Only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ld_err <= 1'b0;
    else if (state_nx == ERR) ld_err <= 1'b1;
  end

endmodule

// File: tb/tb_wb_controller.sv
module tb_wb_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] aluResult = '0;
  logic [31:0] pc = '0;
  logic [3:0]  rd = '0;
  logic        isLd = 1'b0, isCall = 1'b0, isWb = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy, ld_err;
  logic [15:0] wb_count;

  wb_controller dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .aluResult(aluResult), .pc(pc), .rd(rd), .isLd(isLd), .isCall(isCall),
    .isWb(isWb), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy),
    .ld_err(ld_err), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model in behavioural terms. It tracks:
  //   - whether the controller is out of reset,
  //   - whether a load is pending and how long it has waited,
  //   - whether the controller has failed,
  //   - the write that should be visible after the current edge.
  bit          m_started, m_load, m_failed, m_we;
  int          m_waited;
  int          m_cnt;
  logic [3:0]  m_ld_rd, m_addr;
  logic [31:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_started && !m_load && !m_failed));
    chk({tag, ".rf_we"},    32'(rf_we),    32'(m_we));
    chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(m_addr));
    chk({tag, ".rf_wdata"}, rf_wdata,      m_data);
    chk({tag, ".busy"},     32'(busy),     32'(m_load || m_we || m_failed));
    chk({tag, ".ld_err"},   32'(ld_err),   32'(m_failed));
    chk({tag, ".wb_count"}, 32'(wb_count), 32'(m_cnt));
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    m_started = 0; m_load = 0; m_failed = 0; m_we = 0;
    m_waited = 0; m_cnt = 0; m_ld_rd = '0; m_addr = '0; m_data = '0;
    check_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one cycle of inputs, advance the model, clock once, then compare.
  task automatic cycle(input string tag, input bit v, input bit ld, input bit call,
                       input bit wb, input logic [3:0] r, input logic [31:0] alu,
                       input logic [31:0] p, input bit rv, input logic [31:0] rdat);
    bit ready, wr;
    in_valid = v; isLd = ld; isCall = call; isWb = wb; rd = r;
    aluResult = alu; pc = p; mem_rvalid = rv; mem_rdata = rdat;
    ready = m_started && !m_load && !m_failed;
    wr = 0;
    if (m_load) begin
      if (rv) begin
        wr = 1; m_addr = m_ld_rd; m_data = rdat; m_load = 0;
      end else begin
        m_waited++;
        if (m_waited == 15) begin m_failed = 1; m_load = 0; end
      end
    end else if (ready && v) begin
      if (call)    begin wr = 1; m_addr = 4'd15; m_data = p + 32'd4; end
      else if (ld) begin m_load = 1; m_waited = 0; m_ld_rd = r; end
      else if (wb) begin wr = 1; m_addr = r; m_data = alu; end
    end
    if (wr && m_cnt < 65535) m_cnt++;
    m_we = wr;
    m_started = 1;
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 0, 0, 0, 0, 4'd0, 32'd0, 32'd0, 0, 32'd0);
  endtask

  initial begin
    do_reset("reset");
    idle("first_edge");

    // ALU write to r3
    cycle("alu_req", 1, 0, 0, 1, 4'd3, 32'h0000_00AA, 32'h100, 0, 32'd0);
    chk("alu.we_direct", 32'(rf_we), 32'd1);
    chk("alu.addr_direct", 32'(rf_waddr), 32'd3);
    chk("alu.data_direct", rf_wdata, 32'h0000_00AA);
    chk("alu.cnt_direct", 32'(wb_count), 32'd1);
    idle("alu_after");

    // A call wraps pc+4, and wins over isLd
    cycle("call", 1, 1, 1, 1, 4'd2, 32'h1234, 32'hFFFF_FFFC, 0, 32'd0);
    chk("call.addr_direct", 32'(rf_waddr), 32'd15);
    chk("call.data_direct", rf_wdata, 32'h0);
    chk("call.busy_not_wait", 32'(in_ready), 32'd1);
    idle("call_after");

    // Load to r7, data on the 5th wait cycle
    cycle("ld_req", 1, 1, 0, 0, 4'd7, 32'h5, 32'h200, 0, 32'd0);
    for (int i = 0; i < 4; i++) idle("ld_wait");
    cycle("ld_data", 0, 0, 0, 0, 4'd0, 32'd0, 32'd0, 1, 32'hDEAD_BEEF);
    chk("ld.addr_direct", 32'(rf_waddr), 32'd7);
    chk("ld.data_direct", rf_wdata, 32'hDEAD_BEEF);
    idle("ld_after");

    // Back-to-back ALU writes
    cycle("b2b_0", 1, 0, 0, 1, 4'd4, 32'h1111_0000, 32'd0, 0, 32'd0);
    cycle("b2b_1", 1, 0, 0, 1, 4'd5, 32'h2222_0000, 32'd0, 1, 32'hBAD);
    cycle("b2b_2", 1, 0, 0, 0, 4'd6, 32'h3333_0000, 32'd0, 0, 32'd0);
    idle("b2b_after");

    // Data on the 15th wait cycle still produces a normal write
    cycle("ld15_req", 1, 1, 0, 0, 4'd9, 32'd0, 32'd0, 0, 32'd0);
    for (int i = 0; i < 14; i++) idle("ld15_wait");
    cycle("ld15_data", 0, 0, 0, 0, 4'd0, 32'd0, 32'd0, 1, 32'hCAFE_0015);
    chk("ld15.no_err_direct", 32'(ld_err), 32'd0);
    idle("ld15_after");

    // 15 wait cycles without data end in the sticky error state
    cycle("to_req", 1, 1, 0, 0, 4'd8, 32'd0, 32'd0, 0, 32'd0);
    for (int i = 0; i < 15; i++) idle("to_wait");
    chk("to.err_direct", 32'(ld_err), 32'd1);
    cycle("to_stuck", 1, 0, 0, 1, 4'd1, 32'h77, 32'd0, 1, 32'h88);
    idle("to_stuck2");

    // Reset during WAIT_LD, then a late mem_rvalid
    do_reset("reset2");
    idle("r2_first");
    cycle("r2_ld", 1, 1, 0, 0, 4'd10, 32'd0, 32'd0, 0, 32'd0);
    idle("r2_wait");
    #2;
    do_reset("reset_mid_load");
    cycle("r2_late_rv", 0, 0, 0, 0, 4'd0, 32'd0, 32'd0, 1, 32'hFEED);
    chk("r2.idle_direct", 32'(busy), 32'd0);
    idle("r2_after");

    // Randomised traffic, with a reset before each burst
    for (int b = 0; b < 4; b++) begin
      do_reset("rand_reset");
      for (int i = 0; i < 150; i++) begin
        cycle("rand", ($urandom_range(0, 9) < 7), $urandom_range(0, 1),
              ($urandom_range(0, 4) == 0), $urandom_range(0, 1),
              4'($urandom), $urandom, $urandom,
              ($urandom_range(0, 2) == 0), $urandom);
      end
    end

    // wb_count saturation
    do_reset("sat_reset");
    idle("sat_first");
    for (int i = 0; i < 65540; i++)
      cycle("sat", 1, 0, 0, 1, 4'(i), i, 32'd0, 0, 32'd0);
    chk("sat.cnt_direct", 32'(wb_count), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_controller.md
WB_CONTROLLER -- requirements
Module: wb_controller

Interface
REQ-001 SHALL have the port `clk`: input, 1 bit, the single clock; all state updates on the rising edge.
REQ-002 SHALL have the port `rst_n`: input, 1 bit, asynchronous active-low reset.
REQ-003 SHALL have the port `in_valid`: input, 1 bit; the memory-access stage presents an instruction.
REQ-004 SHALL have the port `in_ready`: output, 1 bit; the controller accepts an instruction this cycle.
REQ-005 SHALL have the port `aluResult`: input, 32 bits, the ALU result of the presented instruction.
REQ-006 SHALL have the port `pc`: input, 32 bits, the PC of the presented instruction.
REQ-007 SHALL have the port `rd`: input, 4 bits, the destination register.
REQ-008 SHALL have the ports `isLd`, `isCall` and `isWb`: inputs, 1 bit each, the instruction class flags.
REQ-009 SHALL have the ports `mem_rvalid` (input, 1 bit) and `mem_rdata` (input, 32 bits): load-return handshake; the data is valid when `mem_rvalid`=1.
REQ-010 SHALL have the ports `rf_we` (output, 1 bit), `rf_waddr` (output, 4 bits) and `rf_wdata` (output, 32 bits): register-file write port, all registered.
REQ-011 SHALL have the port `busy`: output, 1 bit, high whenever the state is not IDLE.
REQ-012 SHALL have the port `ld_err`: output, 1 bit, sticky load-timeout flag.
REQ-013 SHALL have the port `wb_count`: output, 16 bits, count of retired register writes.

Function
REQ-014 SHALL implement the states IDLE, WAIT_LD, WRITE and ERR.
REQ-015 SHALL drive `in_ready`=1 in IDLE and WRITE, and 0 in WAIT_LD and ERR.
REQ-016 SHALL, on accept (`in_valid` & `in_ready`), latch `aluResult`, `pc`, `rd` and the three flags.
REQ-017 SHALL apply these accept transitions, in this priority order:
- `isCall`=1 -> WRITE, with write data = `pc` + 4 (modulo 2^32) and address = 4'd15, ignoring `rd` and `isLd`;
- else `isLd`=1 -> WAIT_LD;
- else `isWb`=1 -> WRITE, with write data = `aluResult` and address = `rd`;
- else no write occurs and the next state is IDLE.
REQ-018 SHALL, in WAIT_LD, use a 4-bit `wait_cnt` that is cleared on entry and increments each cycle in which `mem_rvalid`=0.
REQ-019 SHALL, in WAIT_LD with `mem_rvalid`=1, latch `mem_rdata` as the write data with address = `rd`, and go to WRITE; `mem_rvalid` takes priority over timeout in the same cycle.
REQ-020 SHALL, in WAIT_LD with `mem_rvalid`=0 and `wait_cnt`=14, go to ERR, so that at most 15 wait cycles are tolerated.
REQ-021 SHALL ignore `mem_rvalid` outside WAIT_LD.
REQ-022 SHALL, in WRITE, assert `rf_we`=1 for exactly that cycle with the latched address and data, and increment `wb_count`, saturating at 16'hFFFF.
REQ-023 SHALL, in WRITE, apply REQ-017 to any instruction accepted in the same cycle (back-to-back); if none is accepted, the next state is IDLE.
REQ-024 SHALL hold `rf_we`=0 in IDLE, WAIT_LD and ERR.
REQ-025 SHALL hold `rf_waddr` and `rf_wdata` at their last written values when `rf_we`=0.
REQ-026 SHALL, in ERR, set `ld_err`=1 and hold it; ERR is left only by reset.
REQ-027 SHALL add no other latency: an ALU or call write appears 1 cycle after accept; a load write appears 1 cycle after the `mem_rvalid` cycle.

Reset
REQ-028 SHALL, while `rst_n`=0, immediately force the state to IDLE, `in_ready`=0, `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `busy`=0, `ld_err`=0, `wb_count`=0 and `wait_cnt`=0.
REQ-029 SHALL drive `in_ready`=1 from the first clock edge after `rst_n` rises.
REQ-030 SHALL, on reset during WAIT_LD or WRITE, abandon the pending write with no `rf_we` pulse, and ignore any late `mem_rvalid`.

Verification
REQ-031 SHALL be verified by: ALU instruction (`isWb`=1, `rd`=3, `aluResult`=32'h0000_00AA) accepted -> next cycle `rf_we`=1, `rf_waddr`=3, `rf_wdata`=32'h0000_00AA, `wb_count`=1.
REQ-032 SHALL be verified by: call with `pc`=32'hFFFF_FFFC, `isLd`=1 also set -> next cycle `rf_waddr`=15, `rf_wdata`=32'h0000_0000, and no WAIT_LD entry.
REQ-033 SHALL be verified by: load with `rd`=7, `mem_rvalid` after 5 cycles with `mem_rdata`=32'hDEAD_BEEF -> `in_ready`=0 for those 5 cycles, then one `rf_we` pulse to r7 with 32'hDEAD_BEEF.
REQ-034 SHALL be verified by: load with no `mem_rvalid` for 15 cycles -> ERR, `ld_err`=1, `in_ready`=0, and no `rf_we`; a second run with `mem_rvalid` on the 15th cycle -> a normal write and `ld_err`=0.
REQ-035 SHALL be verified by: back-to-back ALU instructions on consecutive cycles -> `rf_we` high on 2 consecutive cycles with the correct addresses and data.
REQ-036 SHALL be verified by: `rst_n` pulsed low during WAIT_LD, then `mem_rvalid`=1 after release -> no write, all outputs 0, and the state IDLE.
